srom_arb2: RTL and testbench
============================

# srom_arb2

Two-master round-robin arbiter that shares the single-ported 8 KB boot/program ROM slave between the instruction-fetch port (m0) and the data-load port (m1). It sits between the core bus masters and the ROM bus slave. It sequences each access around the slave's one-cycle registered `ready`, and guards against a hung slave with a timeout that completes the access with an error flag.

## Interface
- `TIMEOUT`, 15: REQ cycles without `s_ready` before forced completion; legal 1..255
- `clk`  in  1  clock, all state on posedge
- `rstb`  in  1  asynchronous, active-low reset
- `m0_valid`, `m1_valid`  in  1  master request; held with address/controls stable until that master's ready
- `m0_addr`, `m1_addr`  in  32  byte address
- `m0_size`, `m1_size`  in  2  access size, forwarded unchanged
- `m0_write`, `m1_write`  in  1  write flag, forwarded (ROM ignores writes; they complete normally)
- `m0_wdata`, `m1_wdata`  in  32  write data, forwarded
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse
- `m0_rdata`, `m1_rdata`  out  32  read data, valid only while own ready=1, else 0
- `m0_err`, `m1_err`  out  1  timeout flag, valid only with own ready
- `s_valid`  out  1  slave request
- `s_addr`  out  32  granted master's address
- `s_size`  out  2  granted master's size
- `s_write`  out  1  granted master's write flag
- `s_wdata`  out  32  granted master's write data
- `s_ready`  in  1  slave ready (registered copy of `s_valid`)
- `s_rdata`  in  32  slave read data

## Operation
- States: IDLE, REQ, GAP. Registers: state, `gnt` (1 bit), `last` (1 bit, last served master), 8-bit `tcnt`.
- IDLE: if any `mX_valid`, latch `gnt`, `tcnt`<=0, go REQ. Both valid: grant `~last`. One valid: grant it.
- REQ: `s_valid`=1; `s_addr`/`s_size`/`s_write`/`s_wdata` mux combinationally from granted master.
  - `s_ready`=1: granted ready=1, rdata=`s_rdata`, err=0; `last`<=`gnt`; go GAP.
  - Else if `tcnt`==TIMEOUT-1: granted ready=1, rdata=0, err=1; `last`<=`gnt`; go GAP.
  - Else `tcnt`<=`tcnt`+1.
- GAP: `s_valid`=0, all master ready=0, `s_ready` ignored (slave's stale ready from last REQ cycle). Go IDLE.
- Outside REQ: `s_valid`=0, slave-side buses driven from master `gnt` (don't-care), master ready/err/rdata=0.
- Ungranted master: ready/err/rdata held 0 throughout.
- Granted master dropping valid in REQ (protocol violation): access still completes and pulses ready.
- `mX_valid` seen in GAP is not sampled until IDLE.

## Timing
- Reset (async, `rstb`=0): state=IDLE, `gnt`=0, `last`=1 (m0 wins first tie), `tcnt`=0. All outputs 0: `s_valid`, `mX_ready`, `mX_err`, `mX_rdata`.
- Reset mid-REQ: transaction abandoned, no ready pulse. Outputs 0 immediately (combinational from state).
- Request seen in IDLE at edge t: REQ during cycle t+1. ROM `s_ready` in cycle t+2, master ready in cycle t+2 (latency 2). GAP cycle t+3, IDLE cycle t+4.
- Back-to-back throughput: one access per 4 cycles; alternating masters when both continuously request.
- Timeout: ready/err in the TIMEOUT-th REQ cycle (cycle t+TIMEOUT). TIMEOUT=1 with silent slave: err in cycle t+1.
- `s_ready` and timeout in same cycle: `s_ready` wins, err=0.
- `tcnt` never wraps; it is cleared at entry to REQ.

## Test plan
- Reset: hold `rstb`=0 with both valid -> all outputs 0. Release -> m0 granted first, `s_addr`=m0_addr.
- Single m0 read, addr 0x10, ROM word[4]=0xDEADBEEF -> `m0_ready` pulse 2 cycles after valid sampled, `m0_rdata`=0xDEADBEEF, `m0_err`=0, `m1_ready` never 1.
- Both valid continuously, 4 accesses -> grants m0,m1,m0,m1, each 4 cycles apart. `s_valid` low in every GAP cycle. No double ready from stale `s_ready`.
- Byte offset: m1 reads addr 0x13 -> `m1_rdata` = word[4]>>24 (0x000000DE).
- Timeout: slave `s_ready` tied 0, TIMEOUT=15 -> `m0_ready`=`m0_err`=1, rdata 0, exactly 15 REQ cycles after grant; next grant goes to m1 if pending.
- Assert `rstb`=0 in the REQ cycle -> no ready pulse, `s_valid` drops immediately; after release, request re-served from IDLE.

Source files
------------

// File: rtl/srom_arb2.sv
// Two-master round-robin arbiter in front of the single-ported boot ROM.
// Each access is IDLE -> REQ (until s_ready or timeout) -> GAP, one access in flight at a time.
module srom_arb2 #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [1:0]  m0_size,
    input  logic        m0_write,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [1:0]  m1_size,
    input  logic        m1_write,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [1:0]  s_size,
    output logic        s_write,
    output logic [31:0] s_wdata,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a master holds valid and its request fields stable until its
    // ready pulses for exactly one cycle; the slave answers a held s_valid
    // with a ready registered one cycle later.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] TC_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic       r_gnt;
    logic       r_last;
    logic [7:0] r_tcnt;

    logic w_in_req;
    logic w_timeout;
    logic w_ok;
    logic w_done;
    logic w_err;

    assign w_in_req  = (r_state == ST_REQ);
    assign w_timeout = (r_tcnt == TC_LAST);
    assign w_ok      = w_in_req & s_ready;
    // A real slave response beats a timeout landing in the same cycle.
    assign w_done    = w_in_req & (s_ready | w_timeout);
    assign w_err     = w_in_req & ~s_ready & w_timeout;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= ST_IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_tcnt  <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m0_valid || m1_valid) begin
                        r_gnt   <= (m0_valid && m1_valid) ? ~r_last : m1_valid;
                        r_tcnt  <= 8'd0;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (s_ready || w_timeout) begin
                        r_last  <= r_gnt;
                        r_state <= ST_GAP;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    // The slave's ready seen here is the stale echo of the last REQ cycle.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_valid = w_in_req;
    assign s_addr  = r_gnt ? m1_addr  : m0_addr;
    assign s_size  = r_gnt ? m1_size  : m0_size;
    assign s_write = r_gnt ? m1_write : m0_write;
    assign s_wdata = r_gnt ? m1_wdata : m0_wdata;

    assign m0_ready = w_done & ~r_gnt;
    assign m0_err   = w_err & ~r_gnt;
    assign m0_rdata = (w_ok & ~r_gnt) ? s_rdata : 32'd0;

    assign m1_ready = w_done & r_gnt;
    assign m1_err   = w_err & r_gnt;
    assign m1_rdata = (w_ok & r_gnt) ? s_rdata : 32'd0;

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_srom_arb2.sv
// Directed bench for srom_arb2: a per-cycle vector table plus timeout and mid-REQ reset sequences.
// A second instance with TIMEOUT=2 sees s_ready and the timeout in the same cycle.
module tb_srom_arb2;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        slv_en = 1'b1;

    logic        m0_valid = 1'b0;
    logic [31:0] m0_addr = 32'h10;
    logic [1:0]  m0_size = 2'd2;
    logic        m0_write = 1'b0;
    logic [31:0] m0_wdata = 32'h1111_1111;
    logic        m1_valid = 1'b0;
    logic [31:0] m1_addr = 32'h13;
    logic [1:0]  m1_size = 2'd1;
    logic        m1_write = 1'b1;
    logic [31:0] m1_wdata = 32'h2222_2222;

    logic        m0_ready, m0_err, m1_ready, m1_err, s_valid, s_write, s_ready;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;
    logic [1:0]  s_size, dbg_state;

    logic        t2_m0_ready, t2_m0_err, t2_m1_ready, t2_m1_err, t2_s_valid, t2_s_write, t2_s_ready;
    logic [31:0] t2_m0_rdata, t2_m1_rdata, t2_s_addr, t2_s_wdata, t2_s_rdata;
    logic [1:0]  t2_s_size, t2_dbg_state;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    srom_arb2 #(.TIMEOUT(15)) u_dut (
        .clk(clk), .rstb(rstb),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_size(m0_size), .m0_write(m0_write),
        .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_size(m1_size), .m1_write(m1_write),
        .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_valid(s_valid), .s_addr(s_addr), .s_size(s_size), .s_write(s_write),
        .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata), .o_dbg_state(dbg_state)
    );

    srom_arb2 #(.TIMEOUT(2)) u_dut_t2 (
        .clk(clk), .rstb(rstb),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_size(m0_size), .m0_write(m0_write),
        .m0_wdata(m0_wdata), .m0_ready(t2_m0_ready), .m0_rdata(t2_m0_rdata), .m0_err(t2_m0_err),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_size(m1_size), .m1_write(m1_write),
        .m1_wdata(m1_wdata), .m1_ready(t2_m1_ready), .m1_rdata(t2_m1_rdata), .m1_err(t2_m1_err),
        .s_valid(t2_s_valid), .s_addr(t2_s_addr), .s_size(t2_s_size), .s_write(t2_s_write),
        .s_wdata(t2_s_wdata), .s_ready(t2_s_ready), .s_rdata(t2_s_rdata), .o_dbg_state(t2_dbg_state)
    );

    // ROM contents: word[4]=0xDEADBEEF, every other word 0xC0DE0000|index; byte address shifts the word down.
    function automatic logic [31:0] rom_read(input logic [31:0] addr);
        logic [31:0] w;
        w = (addr[12:2] == 11'd4) ? 32'hDEAD_BEEF : {16'hC0DE, 5'd0, addr[12:2]};
        return w >> {addr[1:0], 3'b000};
    endfunction

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s_ready    <= 1'b0;
            s_rdata    <= 32'd0;
            t2_s_ready <= 1'b0;
            t2_s_rdata <= 32'd0;
        end else begin
            s_ready    <= s_valid & slv_en;
            s_rdata    <= rom_read(s_addr);
            t2_s_ready <= t2_s_valid & slv_en;
            t2_s_rdata <= rom_read(t2_s_addr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rstb;
        logic        m0v;
        logic        m1v;
        logic        e_sv;
        logic        e_g;
        logic        e_r0;
        logic [31:0] e_d0;
        logic        e_r1;
        logic [31:0] e_d1;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v0, input logic v1, input logic sv,
                                input logic g, input logic r0, input logic [31:0] d0,
                                input logic r1, input logic [31:0] d1);
        vec_t v;
        v.rstb = r; v.m0v = v0; v.m1v = v1; v.e_sv = sv; v.e_g = g;
        v.e_r0 = r0; v.e_d0 = d0; v.e_r1 = r1; v.e_d1 = d1;
        return v;
    endfunction

    localparam logic [31:0] D4 = 32'hDEAD_BEEF;
    localparam logic [31:0] DB = 32'h0000_00DE;

    vec_t vecs[24];

    initial begin
        int t_done;
        // One row per cycle: inputs driven at the falling edge, outputs of that cycle expected.
        vecs[0]  = mk(0, 1, 1, 0, 0, 0, 0,  0, 0);
        vecs[1]  = mk(0, 1, 1, 0, 0, 0, 0,  0, 0);
        vecs[2]  = mk(1, 1, 1, 0, 0, 0, 0,  0, 0);
        vecs[3]  = mk(1, 1, 1, 1, 0, 0, 0,  0, 0);
        vecs[4]  = mk(1, 1, 1, 1, 0, 1, D4, 0, 0);
        vecs[5]  = mk(1, 1, 1, 0, 0, 0, 0,  0, 0);
        vecs[6]  = mk(1, 1, 1, 0, 0, 0, 0,  0, 0);
        vecs[7]  = mk(1, 1, 1, 1, 1, 0, 0,  0, 0);
        vecs[8]  = mk(1, 1, 1, 1, 1, 0, 0,  1, DB);
        vecs[9]  = mk(1, 1, 1, 0, 0, 0, 0,  0, 0);
        vecs[10] = mk(1, 1, 1, 0, 0, 0, 0,  0, 0);
        vecs[11] = mk(1, 1, 1, 1, 0, 0, 0,  0, 0);
        vecs[12] = mk(1, 1, 1, 1, 0, 1, D4, 0, 0);
        vecs[13] = mk(1, 0, 1, 0, 0, 0, 0,  0, 0);
        vecs[14] = mk(1, 0, 1, 0, 0, 0, 0,  0, 0);
        vecs[15] = mk(1, 0, 1, 1, 1, 0, 0,  0, 0);
        vecs[16] = mk(1, 0, 1, 1, 1, 0, 0,  1, DB);
        vecs[17] = mk(1, 0, 0, 0, 0, 0, 0,  0, 0);
        vecs[18] = mk(1, 0, 0, 0, 0, 0, 0,  0, 0);
        vecs[19] = mk(1, 1, 0, 0, 0, 0, 0,  0, 0);
        vecs[20] = mk(1, 1, 0, 1, 0, 0, 0,  0, 0);
        vecs[21] = mk(1, 1, 0, 1, 0, 1, D4, 0, 0);
        vecs[22] = mk(1, 0, 0, 0, 0, 0, 0,  0, 0);
        vecs[23] = mk(1, 0, 0, 0, 0, 0, 0,  0, 0);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            rstb = vecs[i].rstb;
            m0_valid = vecs[i].m0v;
            m1_valid = vecs[i].m1v;
            #1;
            chk($sformatf("r%0d_s_valid", i), 32'(s_valid), 32'(vecs[i].e_sv));
            chk($sformatf("r%0d_m0_ready", i), 32'(m0_ready), 32'(vecs[i].e_r0));
            chk($sformatf("r%0d_m0_rdata", i), m0_rdata, vecs[i].e_d0);
            chk($sformatf("r%0d_m0_err", i), 32'(m0_err), 32'd0);
            chk($sformatf("r%0d_m1_ready", i), 32'(m1_ready), 32'(vecs[i].e_r1));
            chk($sformatf("r%0d_m1_rdata", i), m1_rdata, vecs[i].e_d1);
            chk($sformatf("r%0d_m1_err", i), 32'(m1_err), 32'd0);
            chk($sformatf("r%0d_t2_m0", i), {t2_m0_err, t2_m0_ready, t2_m0_rdata[29:0]},
                {1'b0, vecs[i].e_r0, vecs[i].e_d0[29:0]});
            chk($sformatf("r%0d_t2_m1", i), {t2_m1_err, t2_m1_ready, t2_m1_rdata[29:0]},
                {1'b0, vecs[i].e_r1, vecs[i].e_d1[29:0]});
            if (vecs[i].e_sv) begin
                chk($sformatf("r%0d_s_addr", i), s_addr, vecs[i].e_g ? 32'h13 : 32'h10);
                chk($sformatf("r%0d_s_size", i), 32'(s_size), vecs[i].e_g ? 32'd1 : 32'd2);
                chk($sformatf("r%0d_s_write", i), 32'(s_write), 32'(vecs[i].e_g));
                chk($sformatf("r%0d_s_wdata", i), s_wdata, vecs[i].e_g ? 32'h2222_2222 : 32'h1111_1111);
            end
        end

        // Timeout: silent slave, m0 alone is granted, then m1 joins while m0 waits.
        slv_en = 1'b0;
        @(negedge clk);
        m0_valid = 1'b1;
        t_done = -1;
        for (int c = 1; c <= 40 && t_done < 0; c++) begin
            @(negedge clk);
            if (c == 1) m1_valid = 1'b1;
            #1;
            if (c == 2) begin
                chk("t2_timeout_ready", 32'(t2_m0_ready), 32'd1);
                chk("t2_timeout_err", 32'(t2_m0_err), 32'd1);
                chk("t2_timeout_rdata", t2_m0_rdata, 32'd0);
            end
            chk($sformatf("to_c%0d_m1_ready", c), 32'(m1_ready), 32'd0);
            if (m0_ready) begin
                t_done = c;
                chk("to_m0_err", 32'(m0_err), 32'd1);
                chk("to_m0_rdata", m0_rdata, 32'd0);
            end
        end
        chk("to_cycle", 32'(t_done), 32'd15);

        @(negedge clk);
        m0_valid = 1'b0;
        #1 chk("to_gap_s_valid", 32'(s_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("to_next_s_valid", 32'(s_valid), 32'd1);
        chk("to_next_gnt_m1", s_addr, 32'h13);

        // Reset in the REQ cycle: the access is dropped, then re-served from IDLE.
        rstb = 1'b0;
        #1;
        chk("rst_req_s_valid", 32'(s_valid), 32'd0);
        chk("rst_req_m1_ready", 32'(m1_ready), 32'd0);
        chk("rst_req_t2_s_valid", 32'(t2_s_valid), 32'd0);
        @(negedge clk);
        chk("rst_hold_m1_ready", 32'(m1_ready), 32'd0);
        rstb = 1'b1;
        slv_en = 1'b1;
        t_done = -1;
        for (int c = 1; c <= 10 && t_done < 0; c++) begin
            @(negedge clk);
            #1;
            if (m1_ready) begin
                t_done = c;
                chk("rst_re_m1_rdata", m1_rdata, DB);
                chk("rst_re_m1_err", 32'(m1_err), 32'd0);
                chk("rst_re_t2_m1", {t2_m1_err, t2_m1_ready}, 32'd1);
                chk("rst_re_t2_rdata", t2_m1_rdata, DB);
            end
        end
        chk("rst_re_cycle", 32'(t_done), 32'd2);
        m1_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
